// File: rtl/store_buffer_responder.sv
// Data-port responder: in-order posted store buffer that drains into a word RAM; loads return one cycle later.
// The STORE_BUF_FORWARD_EN macro enables store-to-load forwarding; otherwise a load that hits a buffered store stalls.
module store_buffer_responder #(
  parameter int WIDTH     = 22,
  parameter int ADDR_BITS = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_write,
  input  logic                         mem_read,
  input  logic [WIDTH-1:0]             data_adr,
  input  logic [WIDTH-1:0]             write_data,
  output logic [WIDTH-1:0]             read_data,
  output logic                         read_valid,
  output logic                         stall,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a request whose strobe is high is taken at the rising edge
  // only when stall is low; otherwise the requester holds it unchanged.

  logic [ADDR_BITS-1:0] buf_idx  [BUF_DEPTH];
  logic [WIDTH-1:0]     buf_data [BUF_DEPTH];
  logic [WIDTH-1:0]     ram      [2**ADDR_BITS];

  logic [PTR_W-1:0]     head, tail, scan_pos;
  logic [CNT_W-1:0]     count;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 full, hit, store_acc, load_acc, drain;
  logic [WIDTH-1:0]     load_data;
`ifdef STORE_BUF_FORWARD_EN
  logic [WIDTH-1:0]     fwd_data;
`endif

  logic unused_adr_bits;
  assign unused_adr_bits = ^{data_adr[WIDTH-1:ADDR_BITS+2], data_adr[1:0]};

  assign word_idx  = data_adr[ADDR_BITS+1:2];
  assign full      = (count == CNT_W'(BUF_DEPTH));
  assign buf_count = count;

  // Scan oldest to newest so the last match (newest entry) wins.
  always_comb begin
    hit      = 1'b0;
    scan_pos = head;
`ifdef STORE_BUF_FORWARD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < BUF_DEPTH; k++) begin
      scan_pos = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (buf_idx[scan_pos] == word_idx)) begin
        hit = 1'b1;
`ifdef STORE_BUF_FORWARD_EN
        fwd_data = buf_data[scan_pos];
`endif
      end
    end
  end

`ifdef STORE_BUF_FORWARD_EN
  assign stall     = full;
  assign load_data = hit ? fwd_data : ram[word_idx];
`else
  // Without forwarding, a load to a buffered word waits while the buffer drains.
  assign stall     = full | (mem_read & hit);
  assign load_data = ram[word_idx];
`endif

  assign store_acc = mem_write & ~stall;
  assign load_acc  = mem_read & ~stall;
  assign drain     = (count != '0) & ~load_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      if (store_acc) tail <= tail + PTR_W'(1);
      if (drain)     head <= head + PTR_W'(1);
      unique case ({store_acc, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      read_valid <= load_acc;
      if (load_acc) read_data <= load_data;
    end
  end

  // Storage has no reset; a reset edge discards pending stores without writing RAM.
  always_ff @(posedge clk) begin
    if (!rst && store_acc) begin
      buf_idx[tail]  <= word_idx;
      buf_data[tail] <= write_data;
    end
    if (!rst && drain) ram[buf_idx[head]] <= buf_data[head];
  end

endmodule

// File: doc/store_buffer_responder.md
Name: store_buffer_responder

Overview:
- Memory-side responder for the 22-bit processor data port. It receives store requests (mem_write, data_adr, write_data) and load requests (mem_read), and returns load data.
- Stores are posted into a small in-order store buffer. The buffer drains into an internal word-addressed RAM whenever the RAM port is not needed by a load.
- Loads complete with fixed 1-cycle latency. Load data is forwarded from the store buffer when the buffer holds a newer value for the same word.
- Replaces the bare data memory behind the processor's memory stage. It asserts stall when it cannot accept a request.

Parameters:
- WIDTH, 22, data and address width in bits.
- ADDR_BITS, 8, word-index bits; RAM holds 2**ADDR_BITS words.
- BUF_DEPTH, 4, store-buffer entries (power of two, at least 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_write  input  1  store request this cycle.
- mem_read  input  1  load request this cycle.
- data_adr  input  WIDTH  byte address; word index = data_adr[ADDR_BITS+1:2]; bits [1:0] and above ADDR_BITS+1 ignored (aliasing).
- write_data  input  WIDTH  store data.
- read_data  output  WIDTH  load data, valid when read_valid=1.
- read_valid  output  1  pulses for one cycle, one cycle after an accepted load.
- stall  output  1  combinational; request this cycle is NOT accepted and the requester must hold it.
- buf_count  output  $clog2(BUF_DEPTH)+1  current store-buffer occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - Buffer emptied (head=tail=0, buf_count=0); read_data=0; read_valid=0.
  - stall=0 while buffer empty.
  - RAM contents untouched.
  - Pending buffered stores are discarded; reset mid-drain is legal.
- Store buffer: circular FIFO of {word index, data}; head = oldest entry, tail = next free slot; pointers wrap modulo BUF_DEPTH.
- Store accept:
  - Condition: mem_write=1 and stall=0. Entry is written at tail; buf_count increments at the edge.
  - Full (buf_count==BUF_DEPTH): stall=1 and the store is not accepted, even if a drain frees a slot in the same cycle. It is accepted the following cycle.
- Load accept:
  - Condition: mem_read=1 and stall=0.
  - Next cycle: read_valid=1 and read_data = value of the word.
  - Forwarding: the value comes from the newest buffer entry whose index matches, checked by priority from tail-1 back to head. On no match, it comes from RAM.
  - The lookup uses buffer contents as of the start of the request cycle.
- Simultaneous load and store to the same word: the load returns the pre-store value, and the store is enqueued normally.
- When stalled, stall blocks both requests and neither is accepted.
- Drain:
  - Condition: buffer not empty and no accepted load this cycle. The head entry is written to RAM at the edge, head advances, and buf_count decrements.
  - Accepted loads have priority on the RAM port.
  - Store accept and drain in the same cycle: buf_count is unchanged.
- stall sources: full buffer; forwarding hazard (optional feature off only).
- read_valid is 0 on every cycle without a preceding accepted load. read_data holds its last value while read_valid=0.
- No starvation guarantee: continuous back-to-back loads may block draining indefinitely. Stores then stall once the buffer is full.

Optional Feature:
- Macro: STORE_BUF_FORWARD_EN.
- Defined: forwarding behaves as described above. A load never stalls on a buffer hit.
- Undefined: no forwarding path.
  - A load whose word index matches any valid buffer entry asserts stall and is not accepted.
  - The drain proceeds in that cycle despite mem_read=1, until no entry matches. The load is then accepted and served from RAM.
  - A load with no match is accepted and served from RAM as normal.

Test Plan:
- Reset, then load from 0x000010 (RAM preloaded 0x0ABCDE) -> read_valid=1 next cycle, read_data=0x0ABCDE, buf_count=0, stall=0.
- Store 0x3FFFFF to 0x000008, then load 0x000008 on the next cycle:
  - Forward on: read_data=0x3FFFFF one cycle later with no stall.
  - Forward off: stall=1 for one cycle while the entry drains, then read_data=0x3FFFFF.
- Fill the buffer:
  - Setup: BUF_DEPTH=4 stores to 0x0, 0x4, 0x8, 0xC, with mem_read held high on all four cycles to a non-matching address (0x100).
  - Required: buf_count=4 after the fourth store.
  - Fifth store: stall=1 and the store is not accepted.
  - Drop mem_read: one drain occurs, stall=0, and the fifth store is accepted.
- Two stores to 0x14 (0x000111 then 0x000222) held in the buffer, then a load of 0x14 -> read_data=0x000222 (newest entry wins). After a full drain, RAM word 5 = 0x000222.
- Same-cycle store 0x000055 and load to 0x20 (RAM holds 0x000011) -> read_data=0x000011; a subsequent load returns 0x000055.
- Three buffered stores, then rst=1 for one cycle -> buf_count=0, read_valid=0, and RAM unchanged for those addresses.
